// File: rtl/io_uart_tx_sink.sv
// io_uart_tx_sink
// Memory-mapped character-output sink. CPU byte writes are queued in a FIFO
// and shifted out as 8N1 UART frames on tx. A halt write raises halt_req once
// the FIFO and the serializer have fully drained.
//
// Ports
//   clk       : system clock, rising-edge
//   rst       : synchronous active-high reset
//   io_we     : I/O write strobe (one cycle per write)
//   io_addr   : 3'h0 = data byte, 3'h4 = halt, others ignored
//   io_wdata  : byte written at offset 0
//   io_full   : FIFO full, from the registered count
//   overflow  : sticky, a data write arrived while io_full was high
//   tx        : UART serial output, idle high
//   tx_busy   : serializer active or FIFO non-empty
//   halt_req  : halt pending, FIFO empty and serializer idle
module io_uart_tx_sink #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4,
    parameter int SIM      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_we,
    input  logic [2:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic       io_full,
    output logic       overflow,
    output logic       tx,
    output logic       tx_busy,
    output logic       halt_req
);

    localparam int DIV_RAW = (SIM != 0) ? 1 : (CLK_FREQ / BAUD);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH   = 1 << FIFO_AW;

    localparam logic [BCW-1:0]   BAUD_LAST = BCW'(DIV - 1);
    localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               halt_pending_r;
    logic               overflow_r;
    logic [1:0]         state_r;
    logic [7:0]         shift_r;
    logic [2:0]         bit_idx_r;
    logic [BCW-1:0]     baud_cnt_r;
    logic               tx_r;

    logic               push_s;
    logic               pop_s;
    logic               bit_end_s;
    logic               full_s;
    logic [1:0]         state_nxt_s;
    logic [7:0]         shift_nxt_s;
    logic [2:0]         bit_idx_nxt_s;
    logic [BCW-1:0]     baud_nxt_s;
    logic               tx_nxt_s;

    // Full is taken from the registered count, so a same-cycle pop never
    // makes room for a write that arrives while full.
    assign full_s    = (count_r == CNT_FULL);
    assign push_s    = io_we && (io_addr == 3'h0) && !full_s;
    assign pop_s     = (state_r == IDLE) && (count_r != '0);
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    assign io_full   = full_s;
    assign overflow  = overflow_r;
    assign tx        = tx_r;
    assign tx_busy   = (state_r != IDLE) || (count_r != '0);
    assign halt_req  = halt_pending_r && (count_r == '0) && (state_r == IDLE);

    // Serializer next-state: the tx level for the next bit is computed here so
    // that tx itself is a register and changes right after each transition.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_idx_nxt_s = bit_idx_r;
        baud_nxt_s    = baud_cnt_r;
        tx_nxt_s      = tx_r;
        case (state_r)
            IDLE: begin
                baud_nxt_s = '0;
                tx_nxt_s   = 1'b1;
                if (pop_s) begin
                    state_nxt_s = START;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    tx_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s   = DATA;
                    baud_nxt_s    = '0;
                    bit_idx_nxt_s = 3'd0;
                    tx_nxt_s      = shift_r[0];
                end else begin
                    baud_nxt_s = baud_cnt_r + BCW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_nxt_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = STOP;
                        tx_nxt_s    = 1'b1;
                    end else begin
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        tx_nxt_s      = shift_r[1];
                    end
                end else begin
                    baud_nxt_s = baud_cnt_r + BCW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_nxt_s = IDLE;
                    baud_nxt_s  = '0;
                    tx_nxt_s    = 1'b1;
                end else begin
                    baud_nxt_s = baud_cnt_r + BCW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                baud_nxt_s  = '0;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            baud_cnt_r <= baud_nxt_s;
            tx_r       <= tx_nxt_s;
        end
    end

    // FIFO storage; contents are discarded logically by the pointer reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= io_wdata;
        end
    end

    // FIFO pointers, occupancy, overflow flag and halt latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            overflow_r     <= 1'b0;
            halt_pending_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1);
                2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (io_we && (io_addr == 3'h0) && full_s) begin
                overflow_r <= 1'b1;
            end
            if (io_we && (io_addr == 3'h4)) begin
                halt_pending_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_uart_tx_sink.sv
// Directed bench for io_uart_tx_sink. dut_a runs with one cycle per bit,
// dut_b with CLK_FREQ=1000, BAUD=100 (ten cycles per bit) and a bench-side
// receiver that decodes its frames.
module tb_io_uart_tx_sink;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, we_a = 1'b0;
    logic [2:0] addr_a = 3'h0;
    logic [7:0] wdata_a = 8'h00;
    logic       full_a, ovf_a, tx_a, busy_a, halt_a;
    logic       rst_b = 1'b1, we_b = 1'b0;
    logic [2:0] addr_b = 3'h0;
    logic [7:0] wdata_b = 8'h00;
    logic       full_b, ovf_b, tx_b, busy_b, halt_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rx_b [$];
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh  = 8'h00;

    always #5 clk = ~clk;

    io_uart_tx_sink #(.SIM(1)) dut_a (
        .clk(clk), .rst(rst_a), .io_we(we_a), .io_addr(addr_a), .io_wdata(wdata_a),
        .io_full(full_a), .overflow(ovf_a), .tx(tx_a), .tx_busy(busy_a), .halt_req(halt_a)
    );

    io_uart_tx_sink #(.CLK_FREQ(1000), .BAUD(100), .SIM(0)) dut_b (
        .clk(clk), .rst(rst_b), .io_we(we_b), .io_addr(addr_b), .io_wdata(wdata_b),
        .io_full(full_b), .overflow(ovf_b), .tx(tx_b), .tx_busy(busy_b), .halt_req(halt_b)
    );

    // Receiver for dut_b: start bit seen at count 0, data bit i sampled at
    // count 15+10*i (mid-bit), frame accepted at count 95 (mid stop bit).
    always @(negedge clk) begin
        if (rst_b) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (tx_b == 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 14 && rx_cnt <= 84 && (rx_cnt % 10) == 4) begin
                rx_sh[(rx_cnt - 14) / 10] <= tx_b;
            end
            if (rx_cnt == 94) begin
                rx_b.push_back(rx_sh);
                rx_act <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] FRAME_41 = 10'b1_0100_0001_0;

    initial begin
        int lows;
        int highs;
        int waited;
        logic [7:0] got_b;

        // 1. reset hold on dut_a
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_tx", {31'd0, tx_a}, 32'd1);
            check_eq("rst_full", {31'd0, full_a}, 32'd0);
            check_eq("rst_halt", {31'd0, halt_a}, 32'd0);
            check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        end
        check_eq("rst_ovf", {31'd0, ovf_a}, 32'd0);
        rst_a = 1'b0;
        tick();
        check_eq("post_rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("post_rst_busy", {31'd0, busy_a}, 32'd0);

        // 2. single byte 0x41
        we_a = 1'b1; addr_a = 3'h0; wdata_a = 8'h41;
        tick();
        we_a = 1'b0;
        check_eq("push_busy", {31'd0, busy_a}, 32'd1);
        check_eq("push_tx_idle", {31'd0, tx_a}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("frame41_bit%0d", i), {31'd0, tx_a}, {31'd0, FRAME_41[i]});
        end
        tick();
        check_eq("frame41_idle", {31'd0, tx_a}, 32'd1);
        check_eq("frame41_busy", {31'd0, busy_a}, 32'd0);

        // 4. 0x55 then halt on the next cycle
        we_a = 1'b1; addr_a = 3'h0; wdata_a = 8'h55;
        tick();
        addr_a = 3'h4; wdata_a = 8'h00;
        check_eq("halt_pre", {31'd0, halt_a}, 32'd0);
        tick();
        we_a = 1'b0; addr_a = 3'h0;
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("halt_low%0d", i), {31'd0, halt_a}, 32'd0);
            tick();
        end
        check_eq("halt_low_stop", {31'd0, halt_a}, 32'd0);
        tick();
        check_eq("halt_high", {31'd0, halt_a}, 32'd1);
        tick();
        check_eq("halt_hold", {31'd0, halt_a}, 32'd1);

        // 6. reset during DATA bit 3 of 0xA5 with two bytes queued
        rst_a = 1'b1;
        tick();
        check_eq("halt_clr", {31'd0, halt_a}, 32'd0);
        rst_a = 1'b0;
        tick();
        we_a = 1'b1; addr_a = 3'h0; wdata_a = 8'hA5;
        tick();
        wdata_a = 8'h11;
        tick();
        wdata_a = 8'h22;
        tick();
        we_a = 1'b0;
        tick(); tick(); tick();
        check_eq("a5_bit3", {31'd0, tx_a}, 32'd0);
        rst_a = 1'b1;
        tick();
        check_eq("midrst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("midrst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("midrst_full", {31'd0, full_a}, 32'd0);
        rst_a = 1'b0;
        lows = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows = lows + 1;
        end
        check_eq("midrst_quiet", lows, 32'd0);

        // 5. dut_b, DIV=10, byte 0xFF
        tick(); tick();
        rst_b = 1'b0;
        tick();
        we_b = 1'b1; addr_b = 3'h0; wdata_b = 8'hFF;
        tick();
        we_b = 1'b0;
        lows = 0; highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_b === 1'b0) lows = lows + 1;
        end
        for (int i = 0; i < 90; i++) begin
            tick();
            if (tx_b === 1'b1) highs = highs + 1;
        end
        check_eq("ff_start_low", lows, 32'd10);
        check_eq("ff_high", highs, 32'd90);
        tick(); tick();
        check_eq("ff_rx_n", rx_b.size(), 32'd1);
        got_b = (rx_b.size() > 0) ? rx_b.pop_front() : 8'h00;
        check_eq("ff_rx_byte", {24'd0, got_b}, 32'hFF);

        // 3. fill dut_b's FIFO while it serializes a priming byte 0xEE
        we_b = 1'b1; wdata_b = 8'hEE;
        tick();
        we_b = 1'b0;
        tick(); tick();
        for (int i = 0; i < 17; i++) begin
            we_b = 1'b1; wdata_b = 8'(i);
            tick();
            if (i == 14) check_eq("fill15_full", {31'd0, full_b}, 32'd0);
            if (i == 15) begin
                check_eq("fill16_full", {31'd0, full_b}, 32'd1);
                check_eq("fill16_ovf", {31'd0, ovf_b}, 32'd0);
            end
        end
        we_b = 1'b0;
        check_eq("fill17_ovf", {31'd0, ovf_b}, 32'd1);
        check_eq("fill17_full", {31'd0, full_b}, 32'd1);
        waited = 0;
        while (rx_b.size() < 17 && waited < 2500) begin
            tick();
            waited = waited + 1;
        end
        for (int i = 0; i < 150; i++) tick();
        check_eq("fill_rx_n", rx_b.size(), 32'd17);
        for (int i = 0; i < 17; i++) begin
            got_b = (i < rx_b.size()) ? rx_b[i] : 8'hXX;
            check_eq($sformatf("fill_rx%0d", i), {24'd0, got_b},
                     (i == 0) ? 32'hEE : 32'(i - 1));
        end
        check_eq("fill_drain_full", {31'd0, full_b}, 32'd0);
        check_eq("fill_drain_busy", {31'd0, busy_b}, 32'd0);
        check_eq("fill_ovf_sticky", {31'd0, ovf_b}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
